// File: rtl/data_ram_sync.sv
// -----------------------------------------------------------------------------
// data_ram_sync
//   Clocked data RAM for the MEM stage. It accepts byte-addressed load/store
//   requests of 1/2/4/8 bytes over a valid/ready handshake and answers one cycle
//   later. After reset it sweeps zeros through every word before accepting
//   requests. It flags illegal sizes, misaligned accesses and out-of-range
//   accesses.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   request handshake
//   req_we            1 = store, 0 = load
//   req_addr          byte address
//   req_size          00 byte, 01 half, 10 word, 11 dword (DATA_W=64 only)
//   req_unsigned      load zero-extends when 1, sign-extends when 0
//   req_wdata         store data, right-aligned
//   rsp_valid/ready   response handshake, at most one outstanding
//   rsp_rdata         load result, right-aligned and extended (0 otherwise)
//   rsp_err           request was rejected
//   init_done         clear sweep finished
// -----------------------------------------------------------------------------
module data_ram_sync #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              ld_q, ld_d;          // response carries load data
    logic [OFF_W-1:0]  off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [DATA_W-1:0] rd_word_q;

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------- request decode ----------------
    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  mem_idx;
    logic [OFF_W-1:0]  align_mask;
    logic              err, accept, wr_en, clr_en;
    logic [LANES-1:0]  be;
    logic [DATA_W-1:0] wdata_sh;

    assign off     = req_addr[OFF_W-1:0];
    assign idx     = req_addr[ADDR_W-1:OFF_W];
    assign mem_idx = req_addr[OFF_W +: CNT_W];

    always_comb begin
        int o, n;
        align_mask = OFF_W'((32'd1 << req_size) - 32'd1);
        // Priority is irrelevant to the outcome: every error class has the
        // same effect (no write, err=1, rdata=0).
        err = ((req_size == 2'b11) && (DATA_W < 64))
           || ((off & align_mask) != '0)
           || (idx >= IDX_W'(DEPTH));
        o = int'(off);
        n = 1 << req_size;
        be = '0;
        for (int l = 0; l < LANES; l++) begin
            be[l] = (l >= o) && (l < o + n);
        end
        // Shifting the store data up by the byte offset lines byte 0 up with
        // lane 'off'; bytes past the access size are masked off by be.
        wdata_sh = req_wdata << {off, 3'b000};
    end

    assign req_ready = init_done && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign wr_en     = accept && req_we && !err;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            ld_q        <= 1'b0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            ld_q        <= ld_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_INIT && cnt_q == CNT_W'(DEPTH - 1)) state_d = S_RUN;
    end

    always_comb begin
        clr_en    = (state_q == S_INIT);
        init_done = (state_q == S_RUN);
        cnt_d     = clr_en ? cnt_q + 1'b1 : cnt_q;
    end

    // ---------------- response tracking ----------------
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        ld_d        = ld_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = err;
            ld_d        = !req_we && !err;
            off_d       = off;
            size_d      = req_size;
            uns_d       = req_unsigned;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            ld_d        = 1'b0;
        end
    end

    // ---------------- storage ----------------
    // Contents are not reset; the INIT sweep clears them instead. The read
    // happens at the accept edge, after any store committed on an earlier edge.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (be[l]) mem[mem_idx][8*l +: 8] <= wdata_sh[8*l +: 8];
            end
        end
        if (accept) rd_word_q <= mem[mem_idx];
    end

    // ---------------- load extract / extend ----------------
    always_comb begin
        logic [DATA_W-1:0] sh, keep, msb_mask;
        int nbits;
        sh        = rd_word_q >> {off_q, 3'b000};
        nbits     = 8 << size_q;
        keep      = ~({DATA_W{1'b1}} << nbits);
        msb_mask  = keep ^ (keep >> 1);
        rsp_rdata = '0;
        if (ld_q) begin
            if (nbits >= DATA_W) rsp_rdata = sh;
            else if (!uns_q && |(sh & msb_mask)) rsp_rdata = (sh & keep) | ~keep;
            else rsp_rdata = sh & keep;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

endmodule
